pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake, optional skid entry, synchronous flush and a saturating stall counter. It is the next generation of the fixed 3×32-bit fetch/decode register. Instances sit between any two pipeline stages (F/D, D/E, E/M, M/W). Each stage boundary can apply back-pressure and flush without external enable gymnastics.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg_sat_counter.sv | 39 +++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and width constants for pipeline stage registers.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT = 96;
    localparam int CNT_W_DEFAULT  = 16;

    // Per-boundary payload widths
    localparam int FD_W = 96;
    localparam int DE_W = 128;
    localparam int EM_W = 96;
    localparam int MW_W = 64;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; cleared only by reset.
// Revision : 1.0
// ============================================================================
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline register with optional skid entry, flush
//            and saturating stall counter.
// Revision : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SKID   = 1,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              up_xfer;
    logic              dn_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign up_xfer   = in_valid && in_ready;
    assign dn_xfer   = out_valid && out_ready;

    // With SKID=0, in_ready is low whenever FULL stalls, so ST_SKID is unreachable.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (up_xfer && dn_xfer) begin
                        main_d = in_data;
                    end else if (dn_xfer) begin
                        state_d = ST_EMPTY;
                    end else if (up_xfer) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (dn_xfer) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            always_comb begin
                in_ready_d = (state_d != ST_SKID);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed bench for a SKID=1 (CNT_W=4) and a SKID=0 instance.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W1 = 96;
    localparam int C1 = 4;
    localparam int W0 = 32;
    localparam int C0 = 16;

    logic clk = 1'b0;
    logic rst;

    logic          s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [W1-1:0] s1_in_data, s1_out_data;
    logic [C1-1:0] s1_stall;

    logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [W0-1:0] s0_in_data, s0_out_data;
    logic [C0-1:0] s0_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W1), .SKID(1), .CNT_W(C1)) u_s1 (
        .clk(clk), .rst(rst), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .stall_cnt(s1_stall)
    );

    pipe_stage_reg #(.DATA_W(W0), .SKID(0), .CNT_W(C0)) u_s0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .stall_cnt(s0_stall)
    );

    task automatic test_reset();
        rst = 1'b1;
        s1_flush = 0; s1_in_valid = 0; s1_in_data = '0; s1_out_ready = 0;
        s0_flush = 0; s0_in_valid = 0; s0_in_data = '0; s0_out_ready = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s1_valid: got %b exp 0", s1_out_valid); end
        n_cmp++; if (s1_out_data !== '0) begin n_err++; $display("FAIL reset_s1_data: got %h exp 0", s1_out_data); end
        n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_s1_in_ready: got %b exp 1", s1_in_ready); end
        n_cmp++; if (s1_stall !== 4'd0) begin n_err++; $display("FAIL reset_s1_stall: got %0d exp 0", s1_stall); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s0_valid: got %b exp 0", s0_out_valid); end
        n_cmp++; if (s0_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_s0_in_ready: got %b exp 1", s0_in_ready); end
        n_cmp++; if (s0_stall !== 16'd0) begin n_err++; $display("FAIL reset_s0_stall: got %0d exp 0", s0_stall); end
        // release reset with flush and a valid beat in the same cycle
        rst = 1'b0;
        s1_flush = 1; s1_in_valid = 1; s1_in_data = {3{32'hDEAD_BEEF}};
        s0_flush = 1; s0_in_valid = 1; s0_in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL rstflush_s1_valid: got %b exp 0", s1_out_valid); end
        n_cmp++; if (s1_out_data !== '0) begin n_err++; $display("FAIL rstflush_s1_data: got %h exp 0", s1_out_data); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_err++; $display("FAIL rstflush_s0_valid: got %b exp 0", s0_out_valid); end
        s1_flush = 0; s1_in_valid = 0; s1_out_ready = 1;
        s0_flush = 0; s0_in_valid = 0; s0_out_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        s1_in_valid = 1; s1_in_data = 96'hA000_0000_0000_0000_0000_0001; s1_out_ready = 1;
        @(negedge clk);
        s1_in_valid = 0;
        n_cmp++; if (s1_out_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid: got %b exp 1", s1_out_valid); end
        n_cmp++; if (s1_out_data !== 96'hA000_0000_0000_0000_0000_0001) begin n_err++; $display("FAIL fill_data: got %h exp a..01", s1_out_data); end
        n_cmp++; if (s1_stall !== 4'd0) begin n_err++; $display("FAIL fill_stall: got %0d exp 0", s1_stall); end
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL fill_drain_valid: got %b exp 0", s1_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W1-1:0] d;
        for (int k = 0; k < 4; k++) begin
            d = {3{32'hB000_0000 + 32'(k)}};
            s1_in_valid = 1; s1_in_data = d; s1_out_ready = 1;
            @(negedge clk);
            n_cmp++; if (s1_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b exp 1", k, s1_out_valid); end
            n_cmp++; if (s1_out_data !== d) begin n_err++; $display("FAIL b2b_data[%0d]: got %h exp %h", k, s1_out_data, d); end
            n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", k, s1_in_ready); end
        end
        s1_in_valid = 0;
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b exp 0", s1_out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [W1-1:0] d1, d2, d3, d4;
        d1 = {3{32'hD1D1_D1D1}}; d2 = {3{32'hD2D2_D2D2}};
        d3 = {3{32'hD3D3_D3D3}}; d4 = {3{32'hD4D4_D4D4}};
        s1_in_valid = 1; s1_in_data = d1; s1_out_ready = 1;
        @(negedge clk);
        n_cmp++; if (s1_out_data !== d1) begin n_err++; $display("FAIL bp_d1: got %h exp %h", s1_out_data, d1); end
        s1_in_data = d2;
        @(negedge clk);
        n_cmp++; if (s1_out_data !== d2) begin n_err++; $display("FAIL bp_d2_main: got %h exp %h", s1_out_data, d2); end
        s1_in_data = d3; s1_out_ready = 0;
        @(negedge clk);
        n_cmp++; if (s1_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_skid_in_ready: got %b exp 0", s1_in_ready); end
        n_cmp++; if (s1_out_data !== d2) begin n_err++; $display("FAIL bp_skid_main: got %h exp %h", s1_out_data, d2); end
        n_cmp++; if (s1_stall !== 4'd1) begin n_err++; $display("FAIL bp_stall1: got %0d exp 1", s1_stall); end
        s1_in_data = d4;  // offered while in_ready is low: must be ignored
        @(negedge clk);
        n_cmp++; if (s1_out_data !== d2) begin n_err++; $display("FAIL bp_hold_main: got %h exp %h", s1_out_data, d2); end
        n_cmp++; if (s1_stall !== 4'd2) begin n_err++; $display("FAIL bp_stall2: got %0d exp 2", s1_stall); end
        s1_in_valid = 0; s1_out_ready = 1;
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_d3_valid: got %b exp 1", s1_out_valid); end
        n_cmp++; if (s1_out_data !== d3) begin n_err++; $display("FAIL bp_d3_data: got %h exp %h", s1_out_data, d3); end
        n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b exp 1", s1_in_ready); end
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b exp 0", s1_out_valid); end
        n_cmp++; if (s1_stall !== 4'd2) begin n_err++; $display("FAIL bp_stall_final: got %0d exp 2", s1_stall); end
    endtask

    task automatic test_flush();
        s1_in_valid = 1; s1_in_data = {3{32'hD5D5_D5D5}}; s1_out_ready = 0;
        @(negedge clk);
        s1_in_data = {3{32'hD6D6_D6D6}};
        @(negedge clk);
        n_cmp++; if (s1_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre_in_ready: got %b exp 0", s1_in_ready); end
        n_cmp++; if (s1_stall !== 4'd3) begin n_err++; $display("FAIL flush_pre_stall: got %0d exp 3", s1_stall); end
        s1_flush = 1; s1_in_data = {3{32'hD9D9_D9D9}}; s1_out_ready = 1;
        @(negedge clk);
        s1_flush = 0; s1_in_valid = 0;
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b exp 0", s1_out_valid); end
        n_cmp++; if (s1_out_data !== '0) begin n_err++; $display("FAIL flush_data: got %h exp 0", s1_out_data); end
        n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b exp 1", s1_in_ready); end
        n_cmp++; if (s1_stall !== 4'd3) begin n_err++; $display("FAIL flush_stall_kept: got %0d exp 3", s1_stall); end
        @(negedge clk);
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_d9: got %b exp 0", s1_out_valid); end
    endtask

    task automatic test_async_reset();
        s1_in_valid = 1; s1_in_data = {3{32'hD7D7_D7D7}}; s1_out_ready = 0;
        s0_in_valid = 1; s0_in_data = 32'h7777_0007;      s0_out_ready = 0;
        @(negedge clk);
        s1_in_valid = 0; s0_in_valid = 0;
        n_cmp++; if (s1_out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_s1: got %b exp 1", s1_out_valid); end
        n_cmp++; if (s0_out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_s0: got %b exp 1", s0_out_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL areset_s1_valid: got %b exp 0", s1_out_valid); end
        n_cmp++; if (s1_out_data !== '0) begin n_err++; $display("FAIL areset_s1_data: got %h exp 0", s1_out_data); end
        n_cmp++; if (s1_stall !== 4'd0) begin n_err++; $display("FAIL areset_s1_stall: got %0d exp 0", s1_stall); end
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_err++; $display("FAIL areset_s0_valid: got %b exp 0", s0_out_valid); end
        n_cmp++; if (s0_out_data !== '0) begin n_err++; $display("FAIL areset_s0_data: got %h exp 0", s0_out_data); end
        @(negedge clk);
        rst = 1'b0; s1_out_ready = 1; s0_out_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [C1-1:0] exp_cnt;
        s1_in_valid = 1; s1_in_data = {3{32'h5A5A_5A5A}}; s1_out_ready = 0;
        @(negedge clk);
        s1_in_valid = 0;
        n_cmp++; if (s1_stall !== 4'd0) begin n_err++; $display("FAIL sat_start: got %0d exp 0", s1_stall); end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            n_cmp++; if (s1_stall !== exp_cnt) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, s1_stall, exp_cnt); end
        end
        n_cmp++; if (s1_out_data !== {3{32'h5A5A_5A5A}}) begin n_err++; $display("FAIL sat_hold_data: got %h exp 5a5a..", s1_out_data); end
        s1_flush = 1;
        @(negedge clk);
        s1_flush = 0;
        n_cmp++; if (s1_stall !== 4'd15) begin n_err++; $display("FAIL sat_after_flush: got %0d exp 15", s1_stall); end
        n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL sat_flush_valid: got %b exp 0", s1_out_valid); end
        @(negedge clk);
        n_cmp++; if (s1_stall !== 4'd15) begin n_err++; $display("FAIL sat_idle_hold: got %0d exp 15", s1_stall); end
    endtask

    task automatic test_skid0_ready();
        s0_in_valid = 1; s0_in_data = 32'h1111_0001; s0_out_ready = 0;
        @(negedge clk);
        s0_in_valid = 0;
        n_cmp++; if (s0_out_valid !== 1'b1) begin n_err++; $display("FAIL s0_load_valid: got %b exp 1", s0_out_valid); end
        n_cmp++; if (s0_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready_low: got %b exp 0", s0_in_ready); end
        s0_out_ready = 1; #1;
        n_cmp++; if (s0_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_ready_follow_hi: got %b exp 1", s0_in_ready); end
        s0_out_ready = 0; #1;
        n_cmp++; if (s0_in_ready !== 1'b0) begin n_err++; $display("FAIL s0_ready_follow_lo: got %b exp 0", s0_in_ready); end
        s0_out_ready = 1;
    endtask

    task automatic test_skid0_stream();
        logic [W0-1:0] d;
        for (int k = 0; k < 5; k++) begin
            d = 32'h5000_0000 + 32'(k);
            s0_in_valid = 1; s0_in_data = d; s0_out_ready = 1;
            @(negedge clk);
            n_cmp++; if (s0_out_valid !== 1'b1) begin n_err++; $display("FAIL s0_stream_valid[%0d]: got %b exp 1", k, s0_out_valid); end
            n_cmp++; if (s0_out_data !== d) begin n_err++; $display("FAIL s0_stream_data[%0d]: got %h exp %h", k, s0_out_data, d); end
            n_cmp++; if (s0_in_ready !== 1'b1) begin n_err++; $display("FAIL s0_stream_ready[%0d]: got %b exp 1", k, s0_in_ready); end
        end
        s0_in_valid = 0;
        @(negedge clk);
        n_cmp++; if (s0_out_valid !== 1'b0) begin n_err++; $display("FAIL s0_drain: got %b exp 0", s0_out_valid); end
        n_cmp++; if (s0_stall !== 16'd0) begin n_err++; $display("FAIL s0_stall: got %0d exp 0", s0_stall); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_skid0_ready();
        test_skid0_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
